vga_raster_writer: RTL and testbench
====================================

VGA_RASTER_WRITER -- requirements
Module: vga_raster_writer

Interface
REQ-001 SHALL have parameter BITS_PER_CHANNEL, default 1: bits per colour channel.
REQ-002 SHALL have parameter CHANNELS, default 3: colour channels per pixel.
REQ-003 SHALL have parameter WIDTH, default 336: framebuffer columns.
REQ-004 SHALL have parameter HEIGHT, default 210: framebuffer rows.
REQ-005 SHALL derive local widths XW=$clog2(WIDTH), YW=$clog2(HEIGHT), AW=$clog2(WIDTH*HEIGHT).
REQ-006 SHALL have port clk, input, 1: single clock for all logic.
REQ-007 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port cmd_valid, input, 1: command present.
REQ-009 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid && cmd_ready.
REQ-010 SHALL have port cmd_op, input, 2: 0=PLOT, 1=FILL, 2=CLEAR, 3=reserved.
REQ-011 SHALL have ports cmd_x0/cmd_x1, input, XW: column start/end (inclusive).
REQ-012 SHALL have ports cmd_y0/cmd_y1, input, YW: row start/end (inclusive).
REQ-013 SHALL have port cmd_color, input, CHANNELS*BITS_PER_CHANNEL: pixel colour.
REQ-014 SHALL have ports write_addr (AW), write_data (CHANNELS*BITS_PER_CHANNEL), write_enable (1), outputs: framebuffer write port.
REQ-015 SHALL have port busy, output, 1: high while not in IDLE.
REQ-016 SHALL have port drop_count, output, 8: saturating count of rejected commands/pixels.

Function
REQ-017 SHALL implement FSM states IDLE, PLOT, FILL, CLEAR; cmd_ready = 1 only in IDLE.
REQ-018 SHALL, on PLOT accept, register operands, go PLOT, assert write_enable for exactly one cycle the cycle after acceptance, return to IDLE.
REQ-019 SHALL compute write_addr = y*WIDTH + x, truncated to AW bits.
REQ-020 SHALL, for PLOT with x0>=WIDTH or y0>=HEIGHT, perform no write, increment drop_count, return to IDLE the next cycle.
REQ-021 SHALL, on FILL accept, clamp x1 to WIDTH-1 and y1 to HEIGHT-1, then write every pixel of [x0..x1]x[y0..y1] in raster order (x inner), one pixel per cycle, first write the cycle after acceptance.
REQ-022 SHALL advance FILL address incrementally: +1 along a row; new row base = previous row base + WIDTH (no per-pixel multiply).
REQ-023 SHALL, for FILL with x0>x1 or y0>y1 (after clamping) or x0/y0 out of range, write nothing, increment drop_count, return to IDLE next cycle.
REQ-024 SHALL, on CLEAR accept, write cmd_color to addresses 0..WIDTH*HEIGHT-1 ascending, one per cycle, then return to IDLE.
REQ-025 SHALL treat cmd_op=3 as dropped: increment drop_count, no write.
REQ-026 SHALL return to IDLE the cycle after the last write; cmd_ready high that cycle.
REQ-027 SHALL saturate drop_count at 255.
REQ-028 SHALL hold write_data constant for a whole FILL/CLEAR and ignore input changes while busy.

Reset
REQ-029 SHALL, while reset_n=0, force IDLE, cmd_ready=1 after release, write_enable=0, write_addr=0, write_data=0, busy=0, drop_count=0.
REQ-030 SHALL abort any FILL/CLEAR on reset assertion with no further writes; partial framebuffer contents remain.

Structure
REQ-031 SHALL place the cmd_op enum and FSM state enum in shared package vga_pkg.
REQ-032 SHALL use one sub-module, vga_addr_gen (x/y counters, row base, last-pixel flag), instantiated once.

Verification
REQ-033 SHALL verify PLOT x=5,y=2,color=3'b101 -> one write, addr=677, data=101, one cycle after accept.
REQ-034 SHALL verify FILL x0=1,x1=3,y0=0,y1=1 -> 6 writes, addrs 1,2,3,337,338,339 consecutive, then IDLE.
REQ-035 SHALL verify CLEAR -> exactly 70560 writes, addrs 0..70559, busy high throughout, then cmd_ready=1.
REQ-036 SHALL verify PLOT x=336,y=0 and FILL x0=4,x1=2 -> no writes, drop_count=2.
REQ-037 SHALL verify FILL x0=330,x1=400,y0=209,y1=300 -> clamped to 6 writes, addrs 70554..70559.
REQ-038 SHALL verify reset_n low mid-CLEAR at pixel 100 -> write_enable=0 immediately, IDLE after release, drop_count=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types for the VGA raster writer.
//   vga_op_e    : command opcode carried on cmd_op
//   vga_state_e : writer FSM state
package vga_pkg;

  typedef enum logic [1:0] {
    OP_PLOT  = 2'd0,
    OP_FILL  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RSVD  = 2'd3
  } vga_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLOT  = 2'd1,
    ST_FILL  = 2'd2,
    ST_CLEAR = 2'd3
  } vga_state_e;

endpackage

// File: rtl/vga_addr_gen.sv
// Rectangle raster walker for the VGA writer.
// Ports:
//   load_i           : capture a rectangle [x0..x1]x[y0..y1]; addr_o = y0*WIDTH+x0
//   step_i           : advance one pixel in raster order (x inner)
//   x0_i/y0_i/x1_i/y1_i : rectangle corners (inclusive, already validated)
//   addr_o           : current pixel address
//   last_o           : current pixel is the final one of the rectangle
// The only multiply happens at load; walking uses +1 along a row and
// +WIDTH on the row base when wrapping to the next row.
module vga_addr_gen
  import vga_pkg::*;
#(
  parameter int WIDTH  = 336,
  parameter int HEIGHT = 210,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT),
  parameter int AW     = $clog2(WIDTH*HEIGHT)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [XW-1:0] x0_i,
  input  logic [YW-1:0] y0_i,
  input  logic [XW-1:0] x1_i,
  input  logic [YW-1:0] y1_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);

  localparam logic [AW-1:0] W_A = AW'(WIDTH);

  logic [XW-1:0] x_q, x_d, x0_q, x0_d, x1_q, x1_d;
  logic [YW-1:0] y_q, y_d, y1_q, y1_d;
  logic [AW-1:0] row_q, row_d, addr_q, addr_d;
  logic [AW-1:0] start_addr;

  assign start_addr = AW'(y0_i) * W_A + AW'(x0_i);
  assign last_o     = (x_q == x1_q) && (y_q == y1_q);
  assign addr_o     = addr_q;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    x0_d   = x0_q;
    x1_d   = x1_q;
    y1_d   = y1_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (load_i) begin
      x_d    = x0_i;
      y_d    = y0_i;
      x0_d   = x0_i;
      x1_d   = x1_i;
      y1_d   = y1_i;
      row_d  = start_addr;
      addr_d = start_addr;
    end else if (step_i) begin
      if (x_q == x1_q) begin
        // row_q tracks the address of column x0 on the current row
        x_d    = x0_q;
        y_d    = y_q + YW'(1);
        row_d  = row_q + W_A;
        addr_d = row_q + W_A;
      end else begin
        x_d    = x_q + XW'(1);
        addr_d = addr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q    <= '0;
      y_q    <= '0;
      x0_q   <= '0;
      x1_q   <= '0;
      y1_q   <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      x0_q   <= x0_d;
      x1_q   <= x1_d;
      y1_q   <= y1_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/vga_raster_writer.sv
// Command-driven framebuffer writer: PLOT one pixel, FILL a clamped
// rectangle, or CLEAR the whole frame, one pixel write per cycle.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   cmd_valid/cmd_ready   : command handshake (ready only in IDLE)
//   cmd_op                : 0 PLOT, 1 FILL, 2 CLEAR, 3 reserved (dropped)
//   cmd_x0/x1, cmd_y0/y1  : inclusive rectangle corners
//   cmd_color             : pixel colour, latched at accept
//   write_addr/data/enable: framebuffer write port
//   busy                  : FSM not in IDLE
//   drop_count            : saturating count of rejected commands
module vga_raster_writer
  import vga_pkg::*;
#(
  parameter int BITS_PER_CHANNEL = 1,
  parameter int CHANNELS         = 3,
  parameter int WIDTH            = 336,
  parameter int HEIGHT           = 210
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [1:0]                         cmd_op,
  input  logic [$clog2(WIDTH)-1:0]           cmd_x0,
  input  logic [$clog2(WIDTH)-1:0]           cmd_x1,
  input  logic [$clog2(HEIGHT)-1:0]          cmd_y0,
  input  logic [$clog2(HEIGHT)-1:0]          cmd_y1,
  input  logic [CHANNELS*BITS_PER_CHANNEL-1:0] cmd_color,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]    write_addr,
  output logic [CHANNELS*BITS_PER_CHANNEL-1:0] write_data,
  output logic                               write_enable,
  output logic                               busy,
  output logic [7:0]                         drop_count
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int AW = $clog2(WIDTH*HEIGHT);
  localparam int DW = CHANNELS*BITS_PER_CHANNEL;

  // One extra bit so the bounds still fit when WIDTH/HEIGHT is a power of two
  localparam logic [XW:0]   W_L   = (XW+1)'(WIDTH);
  localparam logic [YW:0]   H_L   = (YW+1)'(HEIGHT);
  localparam logic [XW-1:0] X_MAX = XW'(WIDTH-1);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT-1);

  vga_state_e    state_q, state_d;
  logic [DW-1:0] color_q, color_d;
  logic [7:0]    drop_q, drop_d;

  logic          load, step, drop, last;
  logic [XW-1:0] lx0, lx1, x1_clamp;
  logic [YW-1:0] ly0, ly1, y1_clamp;
  logic          x0_ok, y0_ok;

  assign x0_ok    = {1'b0, cmd_x0} < W_L;
  assign y0_ok    = {1'b0, cmd_y0} < H_L;
  assign x1_clamp = ({1'b0, cmd_x1} >= W_L) ? X_MAX : cmd_x1;
  assign y1_clamp = ({1'b0, cmd_y1} >= H_L) ? Y_MAX : cmd_y1;

  vga_addr_gen #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .XW    (XW),
    .YW    (YW),
    .AW    (AW)
  ) u_addr_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .load_i (load),
    .step_i (step),
    .x0_i   (lx0),
    .y0_i   (ly0),
    .x1_i   (lx1),
    .y1_i   (ly1),
    .addr_o (write_addr),
    .last_o (last)
  );

  always_comb begin
    state_d      = state_q;
    load         = 1'b0;
    step         = 1'b0;
    drop         = 1'b0;
    cmd_ready    = 1'b0;
    write_enable = 1'b0;
    lx0          = cmd_x0;
    ly0          = cmd_y0;
    lx1          = cmd_x0;
    ly1          = cmd_y0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (vga_op_e'(cmd_op))
            OP_PLOT: begin
              if (x0_ok && y0_ok) begin
                load    = 1'b1;
                state_d = ST_PLOT;
              end else begin
                drop = 1'b1;
              end
            end
            OP_FILL: begin
              lx1 = x1_clamp;
              ly1 = y1_clamp;
              if (x0_ok && y0_ok && cmd_x0 <= x1_clamp && cmd_y0 <= y1_clamp) begin
                load    = 1'b1;
                state_d = ST_FILL;
              end else begin
                drop = 1'b1;
              end
            end
            OP_CLEAR: begin
              // whole frame as one rectangle walks 0..WIDTH*HEIGHT-1 ascending
              lx0     = '0;
              ly0     = '0;
              lx1     = X_MAX;
              ly1     = Y_MAX;
              load    = 1'b1;
              state_d = ST_CLEAR;
            end
            default: drop = 1'b1;
          endcase
        end
      end
      ST_PLOT: begin
        write_enable = 1'b1;
        state_d      = ST_IDLE;
      end
      ST_FILL, ST_CLEAR: begin
        write_enable = 1'b1;
        step         = 1'b1;
        if (last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    color_d = load ? cmd_color : color_q;
    drop_d  = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      color_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      color_q <= color_d;
      drop_q  <= drop_d;
    end
  end

  assign write_data = color_q;
  assign busy       = (state_q != ST_IDLE);
  assign drop_count = drop_q;

endmodule

// File: tb/tb_vga_raster_writer.sv
// Directed bench for vga_raster_writer (default 336x210, 3-bit colour).
module tb_vga_raster_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [8:0]  cmd_x0, cmd_x1;
  logic [7:0]  cmd_y0, cmd_y1;
  logic [2:0]  cmd_color;
  logic [16:0] write_addr;
  logic [2:0]  write_data;
  logic        write_enable;
  logic        busy;
  logic [7:0]  drop_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc, idle_cyc;
  int wa[$], wd[$], wc[$];
  int nobusy = 0;

  vga_raster_writer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_x0      (cmd_x0),
    .cmd_x1      (cmd_x1),
    .cmd_y0      (cmd_y0),
    .cmd_y1      (cmd_y1),
    .cmd_color   (cmd_color),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .write_enable(write_enable),
    .busy        (busy),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // write monitor
  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      wa.push_back(int'(write_addr));
      wd.push_back(int'(write_data));
      wc.push_back(cyc);
      if (busy !== 1'b1) nobusy++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr_log();
    wa.delete(); wd.delete(); wc.delete(); nobusy = 0;
  endtask

  task automatic send(input logic [1:0] op, input int x0, input int x1,
                      input int y0, input int y1, input logic [2:0] c);
    int n = 0;
    @(negedge clk);
    cmd_op = op; cmd_x0 = 9'(x0); cmd_x1 = 9'(x1);
    cmd_y0 = 8'(y0); cmd_y1 = 8'(y1); cmd_color = c; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("accept_ready", cmd_ready, 1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    // scramble inputs: the command must already be latched
    cmd_valid = 1'b0; cmd_op = ~op; cmd_x0 = ~cmd_x0; cmd_x1 = ~cmd_x1;
    cmd_y0 = ~cmd_y0; cmd_y1 = ~cmd_y1; cmd_color = ~c;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    do begin @(negedge clk); #1; n++; end
    while (!(cmd_ready === 1'b1 && busy === 1'b0) && n < max);
    chk("idle_reached", cmd_ready, 1);
    idle_cyc = cyc;
  endtask

  initial begin
    int exp_fill[6];
    int seq_bad, gap_bad, dat_bad, n;
    exp_fill = '{1, 2, 3, 337, 338, 339};
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0;
    cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0; cmd_color = '0;
    repeat (3) @(negedge clk);
    chk("rst_we",    write_enable, 0);
    chk("rst_addr",  write_addr, 0);
    chk("rst_data",  write_data, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_drop",  drop_count, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);

    // PLOT (5,2) -> 2*336+5 = 677
    clr_log();
    send(2'd0, 5, 0, 2, 0, 3'b101);
    wait_idle(20);
    chk("plot_n",    wa.size(), 1);
    chk("plot_addr", wa.size() > 0 ? wa[0] : -1, 677);
    chk("plot_data", wd.size() > 0 ? wd[0] : -1, 5);
    chk("plot_lat",  wc.size() > 0 ? wc[0] : -1, acc_cyc + 1);
    chk("plot_idle", idle_cyc, acc_cyc + 2);

    // FILL x 1..3, y 0..1
    clr_log();
    send(2'd1, 1, 3, 0, 1, 3'b010);
    wait_idle(40);
    chk("fill_n", wa.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("fill_addr%0d", i), i < wa.size() ? wa[i] : -1, exp_fill[i]);
      chk($sformatf("fill_cyc%0d", i),  i < wc.size() ? wc[i] : -1, acc_cyc + 1 + i);
    end
    dat_bad = 0;
    foreach (wd[i]) if (wd[i] != 2) dat_bad++;
    chk("fill_data", dat_bad, 0);
    chk("fill_idle", idle_cyc, acc_cyc + 7);
    chk("fill_drop", drop_count, 0);

    // rejected commands: PLOT off right edge, FILL with x0 > x1, reserved op
    clr_log();
    send(2'd0, 336, 0, 0, 0, 3'b111);
    wait_idle(10);
    chk("drop_plot_idle", idle_cyc, acc_cyc + 1);
    send(2'd1, 4, 2, 0, 0, 3'b111);
    wait_idle(10);
    chk("drop_cnt2", drop_count, 2);
    send(2'd3, 0, 0, 0, 0, 3'b111);
    wait_idle(10);
    chk("drop_cnt3", drop_count, 3);
    chk("drop_writes", wa.size(), 0);

    // FILL clamped: x1 400 -> 335, y1 255 (port max) -> 209; 209*336+330 = 70554
    clr_log();
    send(2'd1, 330, 400, 209, 255, 3'b011);
    wait_idle(40);
    chk("clamp_n", wa.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("clamp_addr%0d", i), i < wa.size() ? wa[i] : -1, 70554 + i);

    // full CLEAR
    clr_log();
    send(2'd2, 0, 0, 0, 0, 3'b110);
    wait_idle(80000);
    chk("clear_n", wa.size(), 70560);
    seq_bad = 0; gap_bad = 0; dat_bad = 0;
    foreach (wa[i]) begin
      if (wa[i] != i) seq_bad++;
      if (wc[i] != acc_cyc + 1 + i) gap_bad++;
      if (wd[i] != 6) dat_bad++;
    end
    chk("clear_seq",   seq_bad, 0);
    chk("clear_gap",   gap_bad, 0);
    chk("clear_data",  dat_bad, 0);
    chk("clear_busy",  nobusy, 0);
    chk("clear_idle",  idle_cyc, acc_cyc + 70561);
    chk("clear_ready", cmd_ready, 1);

    // reset in the middle of a CLEAR
    clr_log();
    send(2'd2, 0, 0, 0, 0, 3'b001);
    n = 0;
    while (wa.size() < 100 && n < 500) begin @(negedge clk); #1; n++; end
    chk("mid_count", wa.size(), 100);
    reset_n = 1'b0;
    #1;
    chk("mid_we",   write_enable, 0);
    chk("mid_busy", busy, 0);
    chk("mid_drop", drop_count, 0);
    chk("mid_addr", write_addr, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("mid_nowr",  wa.size(), 100);
    chk("mid_ready", cmd_ready, 1);
    chk("mid_idle",  busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
